// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: central hazard unit for the 5-stage pipeline.
// Provides EX-stage operand forwarding selects and load-use stall/branch flush control.
// Freezes the whole pipe during cache misses, with a miss watchdog and a
// saturating stall-cycle counter.
module hazard_fwd_ctrl #(
  parameter int MISS_TIMEOUT = 256,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rs1_e,
  input  logic [4:0]       rs2_e,
  input  logic [4:0]       rd_e,
  input  logic             load_e,
  input  logic             pcsrc_e,
  input  logic [4:0]       rd_m,
  input  logic             regwrite_m,
  input  logic [4:0]       rd_w,
  input  logic             regwrite_w,
  input  logic             cache_stall,
  output logic [1:0]       forward_a_e,
  output logic [1:0]       forward_b_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             stall_w,
  output logic             flush_d,
  output logic             flush_e,
  output logic             miss_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_MISS = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  // Last MISS count value before the watchdog trips.
  localparam logic [15:0] MISS_LAST = 16'(MISS_TIMEOUT - 1);

  state_e            state_q;
  logic [15:0]       miss_cnt_q;
  logic              timeout_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              lwstall_s;
  logic              freeze_s;

  // Forwarding select for one source register; MEM beats WB, x0 never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] dst_m,
    input logic       we_m,
    input logic [4:0] dst_w,
    input logic       we_w
  );
    logic [1:0] sel;
    if (we_m && (dst_m != 5'd0) && (dst_m == src)) begin
      sel = 2'b10;
    end else if (we_w && (dst_w != 5'd0) && (dst_w == src)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign forward_a_e = fwd_sel(rs1_e, rd_m, regwrite_m, rd_w, regwrite_w);
  assign forward_b_e = fwd_sel(rs2_e, rd_m, regwrite_m, rd_w, regwrite_w);

  assign lwstall_s = load_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

  // A live miss freezes immediately, even before the FSM has left RUN. MISS only
  // persists while cache_stall stays high, so the cycle the miss clears already
  // runs the normal RUN equations; ERR freezes regardless of cache_stall.
  assign freeze_s = cache_stall || (state_q == ST_ERR);

  // Stall/flush decode: freeze overrides everything, otherwise load-use and branch rules.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    stall_w = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (freeze_s) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      stall_w = 1'b1;
    end else begin
      stall_f = lwstall_s;
      stall_d = lwstall_s;
      flush_d = pcsrc_e;
      flush_e = lwstall_s || pcsrc_e;
    end
  end

  // Miss FSM with watchdog; the sticky timeout flag is registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      miss_cnt_q <= 16'd0;
      timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          miss_cnt_q <= 16'd0;
          if (cache_stall) begin
            state_q <= ST_MISS;
          end
        end
        ST_MISS: begin
          if (!cache_stall) begin
            state_q    <= ST_RUN;
            miss_cnt_q <= 16'd0;
          end else if (miss_cnt_q == MISS_LAST) begin
            state_q   <= ST_ERR;
            timeout_q <= 1'b1;
          end else begin
            miss_cnt_q <= miss_cnt_q + 16'd1;
          end
        end
        ST_ERR: begin
          timeout_q <= 1'b1;
        end
        default: begin
          state_q    <= ST_RUN;
          miss_cnt_q <= 16'd0;
        end
      endcase
    end
  end

  assign miss_timeout = timeout_q;

  // Saturating next value of the stall-cycle counter.
  always_comb begin
    cnt_d = cnt_q;
    if (stall_f && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Stall-cycle counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: directed scenarios plus randomized traffic,
// all checked against a rule-level reference model.
module tb_hazard_fwd_ctrl;
  localparam int TMO  = 8;
  localparam int CW   = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] rs1_d = 5'd0, rs2_d = 5'd0, rs1_e = 5'd0, rs2_e = 5'd0, rd_e = 5'd0;
  logic [4:0] rd_m = 5'd0, rd_w = 5'd0;
  logic load_e = 1'b0, pcsrc_e = 1'b0, regwrite_m = 1'b0, regwrite_w = 1'b0;
  logic cache_stall = 1'b0;
  logic [1:0] forward_a_e, forward_b_e;
  logic stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e, miss_timeout;
  logic [CW-1:0] stall_cycles;

  int total = 0;
  int bad = 0;

  // reference model state
  bit m_err;
  int m_run;
  int m_cnt;
  // model expectations for the current cycle
  int e_fa, e_fb;
  bit e_sf, e_se, e_fd, e_fe;

  hazard_fwd_ctrl #(.MISS_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .load_e(load_e), .pcsrc_e(pcsrc_e),
    .rd_m(rd_m), .regwrite_m(regwrite_m), .rd_w(rd_w), .regwrite_w(regwrite_w),
    .cache_stall(cache_stall),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .stall_w(stall_w), .flush_d(flush_d), .flush_e(flush_e),
    .miss_timeout(miss_timeout), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    total++;
    if (obs != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int ref_fwd(input int src);
    if (regwrite_m && rd_m != 0 && int'(rd_m) == src) return 2;
    if (regwrite_w && rd_w != 0 && int'(rd_w) == src) return 1;
    return 0;
  endfunction

  task automatic model_comb();
    bit lw, frz;
    lw  = load_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
    frz = cache_stall || m_err;
    e_fa = ref_fwd(int'(rs1_e));
    e_fb = ref_fwd(int'(rs2_e));
    e_sf = frz ? 1'b1 : lw;
    e_se = frz;
    e_fd = !frz && pcsrc_e;
    e_fe = !frz && (lw || pcsrc_e);
  endtask

  task automatic model_reset();
    m_err = 1'b0;
    m_run = 0;
    m_cnt = 0;
  endtask

  // one clock: check all outputs mid-cycle, advance model at the edge
  task automatic step();
    #1;
    model_comb();
    chk("fwd_a", forward_a_e, e_fa);
    chk("fwd_b", forward_b_e, e_fb);
    chk("stall_f", stall_f, e_sf);
    chk("stall_d", stall_d, e_sf);
    chk("stall_e", stall_e, e_se);
    chk("stall_m", stall_m, e_se);
    chk("stall_w", stall_w, e_se);
    chk("flush_d", flush_d, e_fd);
    chk("flush_e", flush_e, e_fe);
    chk("miss_timeout", miss_timeout, m_err);
    chk("stall_cycles", stall_cycles, m_cnt);
    @(posedge clk);
    if (e_sf) m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
    if (!m_err) begin
      if (cache_stall) begin
        m_run++;
        if (m_run == TMO + 1) m_err = 1'b1;
      end else begin
        m_run = 0;
      end
    end
    @(negedge clk);
  endtask

  // asynchronous reset pulse starting mid-cycle
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_timeout", miss_timeout, 0);
    chk("rst_cycles", stall_cycles, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_inputs();
    rs1_d = 5'd0; rs2_d = 5'd0; rs1_e = 5'd0; rs2_e = 5'd0; rd_e = 5'd0;
    rd_m = 5'd0; rd_w = 5'd0; load_e = 1'b0; pcsrc_e = 1'b0;
    regwrite_m = 1'b0; regwrite_w = 1'b0; cache_stall = 1'b0;
  endtask

  initial begin
    int burst;
    int snap;
    model_reset();
    @(negedge clk);
    do_reset();
    step();

    // forwarding priority and x0
    rs1_e = 5'd5; rd_m = 5'd5; regwrite_m = 1'b1; rd_w = 5'd5; regwrite_w = 1'b1;
    #1 chk("t1_mem", forward_a_e, 2);
    step();
    regwrite_m = 1'b0;
    #1 chk("t1_wb", forward_a_e, 1);
    step();
    rs1_e = 5'd0; rd_m = 5'd0; rd_w = 5'd0; regwrite_m = 1'b1;
    #1 chk("t1_x0", forward_a_e, 0);
    step();

    // load-use
    clear_inputs();
    load_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
    #1 chk("t2_sf", stall_f, 1); chk("t2_fe", flush_e, 1); chk("t2_fd", flush_d, 0);
    step();
    rd_e = 5'd0;
    #1 chk("t2_x0_sf", stall_f, 0); chk("t2_x0_fe", flush_e, 0);
    step();

    // load-use together with taken branch
    rd_e = 5'd7; pcsrc_e = 1'b1;
    snap = m_cnt;
    #1 chk("t3_fd", flush_d, 1); chk("t3_fe", flush_e, 1); chk("t3_sf", stall_f, 1);
    step();
    chk("t3_cnt", stall_cycles, snap + 1);

    // 5-cycle miss with a pending branch
    clear_inputs();
    pcsrc_e = 1'b1; cache_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("t4_sw", stall_w, 1); chk("t4_fd", flush_d, 0);
      step();
    end
    cache_stall = 1'b0;
    #1 chk("t4_fd6", flush_d, 1); chk("t4_sf6", stall_f, 0);
    step();

    // watchdog
    clear_inputs();
    cache_stall = 1'b1;
    for (int i = 0; i < TMO + 1; i++) step();
    chk("t5_tmo", miss_timeout, 1);
    cache_stall = 1'b0; pcsrc_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t5_hold", stall_f, 1); chk("t5_nofl", flush_d, 0);
      step();
    end
    do_reset();
    step();

    // reset in the 3rd MISS cycle
    clear_inputs();
    cache_stall = 1'b1;
    for (int i = 0; i < 3; i++) step();
    #3;
    cache_stall = 1'b0; load_e = 1'b1; rd_e = 5'd3; rs1_d = 5'd3;
    do_reset();
    #1 chk("t6_sf", stall_f, 1); chk("t6_se", stall_e, 0); chk("t6_cnt", stall_cycles, 0);
    step();

    // randomized traffic
    burst = 0;
    for (int n = 0; n < 3000; n++) begin
      rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
      rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
      rd_e  = 5'($urandom_range(0, 3)); rd_m = 5'($urandom_range(0, 3));
      rd_w  = 5'($urandom_range(0, 3));
      load_e = 1'($urandom_range(0, 1)); pcsrc_e = ($urandom_range(0, 3) == 0);
      regwrite_m = 1'($urandom_range(0, 1)); regwrite_w = 1'($urandom_range(0, 1));
      if (burst == 0 && $urandom_range(0, 9) == 0) burst = $urandom_range(1, 12);
      cache_stall = (burst > 0);
      if (burst > 0) burst--;
      if ($urandom_range(0, 199) == 0) begin
        burst = 0;
        cache_stall = 1'b0;
        do_reset();
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
